mem_mp: RTL and testbench
=========================

Name: mem_mp

Overview:
- Parametrised successor to the 8-bit, 1-write/2-read processor memory.
- Configurable data width, address width and read-port count.
- Adds a hardware clear sequence after reset, registered reads with optional write-to-read bypass, and a memory-mapped halt register.
- Sits between the w450-class core and the testbench; the bench watches `halt` instead of snooping the write bus.

Parameters:
- DW, 8, data width in bits.
- AW, 8, address width; DEPTH = 2**AW words.
- NRD, 2, number of independent read ports (1..4).
- HALT_ADDR, {AW{1'b1}}, MMIO halt/status address; not backed by array storage.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- wr_data  in  DW  write data.
- wr_addr  in  AW  write address.
- wr_en  in  1  write strobe, sampled at posedge.
- rd_addr  in  NRD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NRD*DW  packed registered read data, same packing.
- busy  out  1  high while the clear sequence runs.
- halt  out  1  sticky halt flag.
- wr_count  out  16  accepted-write counter, saturating.

Behaviour:
- Reset (reset=0, async):
  - State=CLEAR, clear pointer=0, rd_data=0, busy=1, halt=0, wr_count=0.
  - Array contents are not reset directly; the CLEAR state zeroes them.
- State machine (2-bit state):
  - CLEAR: writes 0 to array[ptr] each cycle, ptr++. After writing DEPTH-1 the state moves to RUN on the next edge. Exactly DEPTH cycles in CLEAR; busy=1 throughout. While in CLEAR, wr_en is ignored and not counted, and every rd_data port registers 0.
  - RUN: busy=0. A write with wr_en=1:
    - wr_addr != HALT_ADDR: array[wr_addr] <= wr_data, wr_count++.
    - wr_addr == HALT_ADDR and wr_data == 1: state -> HALTED, halt=1, wr_count++.
    - wr_addr == HALT_ADDR and any other data: no effect, wr_count++.
  - HALTED: halt=1, sticky until reset. All writes are ignored and not counted. Reads keep working.
- Reads (RUN and HALTED):
  - rd_data[k] <= array[rd_addr[k]] at posedge, so latency is 1 cycle.
  - rd_addr[k] == HALT_ADDR returns {DW-1 zeros, halt}.
  - Ports are fully independent; identical addresses on several ports are legal.
- Same-cycle write and read to the same address: see Optional Feature.
- wr_count saturates at 16'hFFFF and does not wrap.
- Reset mid-operation (any state) restarts CLEAR from ptr=0; halt is cleared immediately (async).
- AW=1 is legal: DEPTH=2, one of the two addresses is HALT_ADDR.

Optional Feature:
- Macro MEM_BYPASS_EN.
- Defined: a read of the address being written in the same RUN cycle (not HALT_ADDR) registers the new wr_data.
- Undefined: the read registers the old array contents (read-before-write).
- HALT_ADDR reads always return the pre-edge halt value in both builds.

Decomposition:
- Package mem_mp_pkg:
  - state enum: ST_CLEAR, ST_RUN, ST_HALTED.
  - WCNT_W=16.
  - HALT_VALUE=1.
- One sub-module, mem_mp_rdport: a single registered read port with the bypass mux and HALT_ADDR decode, instantiated NRD times via generate.
- The clear FSM and write logic stay in the top module.

Test Plan:
- Clear sequence: release reset at t=30 with AW=8 -> busy=1 for exactly 256 cycles, then 0. Every address reads 8'h00. wr_en pulses during busy do not change memory or wr_count.
- Basic write/read: write 8'hA5 @8'h10 and 8'h3C @8'h20, then rd_addr0=8'h10, rd_addr1=8'h20 -> one cycle later rd_data0=8'hA5, rd_data1=8'h3C. wr_count=2.
- Collision: write 8'h77 @8'h40 (holding 8'h11) while rd_addr0=8'h40 -> rd_data0=8'h77 with MEM_BYPASS_EN, 8'h11 without. The next cycle reads 8'h77 in both builds.
- Halt: write 8'h02 @8'hFF -> halt stays 0, wr_count increments. Then write 8'h01 @8'hFF -> halt=1 after the edge, and reading 8'hFF returns 8'h01. A later write of 8'h99 @8'h10 leaves 8'hA5 and does not change wr_count.
- Reset mid-run: drop reset to 0 while halted and mid-CLEAR -> halt=0, busy=1, rd_data=0 immediately. A full 256-cycle clear follows.
- Parametrised build (DW=16, AW=4, NRD=4): all four ports read distinct addresses in the same cycle and return the correct 16-bit values. HALT_ADDR=4'hF.

Source files
------------

// File: rtl/mem_mp_pkg.sv
// Shared types and constants for the parametrised multi-port processor memory.
package mem_mp_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam int WCNT_W     = 16;
  localparam int HALT_VALUE = 1;

endpackage

// File: rtl/mem_mp_if.sv
// Write/read bus and status signals of mem_mp; master = core/bench, slave = memory.
interface mem_mp_if #(
  parameter int DW  = 8,
  parameter int AW  = 8,
  parameter int NRD = 2
);
  logic [DW-1:0]                  wr_data;
  logic [AW-1:0]                  wr_addr;
  logic                           wr_en;
  logic [NRD*AW-1:0]              rd_addr;
  logic [NRD*DW-1:0]              rd_data;
  logic                           busy;
  logic                           halt;
  logic [mem_mp_pkg::WCNT_W-1:0]  wr_count;

  modport master (
    output wr_data, wr_addr, wr_en, rd_addr,
    input  rd_data, busy, halt, wr_count
  );

  modport slave (
    input  wr_data, wr_addr, wr_en, rd_addr,
    output rd_data, busy, halt, wr_count
  );
endinterface

// File: rtl/mem_mp_rdport.sv
// One registered read port: HALT_ADDR status decode and optional write-to-read bypass.
// Build option: MEM_BYPASS_EN forwards same-cycle write data to a matching read.
module mem_mp_rdport #(
  parameter int            DW        = 8,
  parameter int            AW        = 8,
  parameter logic [AW-1:0] HALT_ADDR = {AW{1'b1}}
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] arr_data,
  input  logic          wr_act,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          halt,
  output logic [DW-1:0] rd_data
);

`ifdef MEM_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // wr_act already excludes HALT_ADDR, so status reads never see bypassed data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if (!rd_en) begin
      rd_data <= '0;
    end else if (rd_addr == HALT_ADDR) begin
      rd_data <= {{(DW-1){1'b0}}, halt};
    end else if (BYPASS && wr_act && (wr_addr == rd_addr)) begin
      rd_data <= wr_data;
    end else begin
      rd_data <= arr_data;
    end
  end

endmodule

// File: rtl/mem_mp.sv
// Parametrised 1-write/NRD-read processor memory with post-reset clear and MMIO halt.
// Build option: MEM_BYPASS_EN (see mem_mp_rdport) selects write-to-read bypass.
module mem_mp
  import mem_mp_pkg::*;
#(
  parameter int            DW        = 8,
  parameter int            AW        = 8,
  parameter int            NRD       = 2,
  parameter logic [AW-1:0] HALT_ADDR = {AW{1'b1}}
) (
  input  logic     clk,
  input  logic     reset,
  mem_mp_if.slave  bus
);
  // state     | meaning
  // ST_CLEAR  | zeroing array[ptr], one word per cycle; writes ignored, reads return 0
  // ST_RUN    | normal operation; writes counted, HALT_ADDR=1 enters ST_HALTED
  // ST_HALTED | sticky halt; writes ignored, reads still served

  localparam int DEPTH = 2 ** AW;

  state_t              state_q, state_d;
  logic [AW-1:0]       ptr_q;
  logic [WCNT_W-1:0]   wcnt_q;
  logic [DW-1:0]       mem [DEPTH];

  logic run_wr;
  logic wr_halt_addr;
  logic wr_act;

  assign run_wr       = (state_q == ST_RUN) && bus.wr_en;
  assign wr_halt_addr = (bus.wr_addr == HALT_ADDR);
  assign wr_act       = run_wr && !wr_halt_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_CLEAR:  if (&ptr_q) state_d = ST_RUN;
      ST_RUN:    if (run_wr && wr_halt_addr && (bus.wr_data == DW'(HALT_VALUE)))
                   state_d = ST_HALTED;
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      ptr_q <= ptr_q + 1'b1;
    end
  end

  // Storage has no reset; the clear sequence is what initialises it
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[ptr_q] <= '0;
    end else if (wr_act) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt_q <= '0;
    end else if (run_wr && (wcnt_q != {WCNT_W{1'b1}})) begin
      wcnt_q <= wcnt_q + 1'b1;
    end
  end

  assign bus.busy     = (state_q == ST_CLEAR);
  assign bus.halt     = (state_q == ST_HALTED);
  assign bus.wr_count = wcnt_q;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] rd_addr_k;
    logic [DW-1:0] arr_k;
    logic [DW-1:0] rd_k;

    assign rd_addr_k = bus.rd_addr[k*AW +: AW];
    assign arr_k     = mem[rd_addr_k];

    mem_mp_rdport #(
      .DW        (DW),
      .AW        (AW),
      .HALT_ADDR (HALT_ADDR)
    ) u_rdport (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (state_q != ST_CLEAR),
      .rd_addr  (rd_addr_k),
      .arr_data (arr_k),
      .wr_act   (wr_act),
      .wr_addr  (bus.wr_addr),
      .wr_data  (bus.wr_data),
      .halt     (bus.halt),
      .rd_data  (rd_k)
    );

    assign bus.rd_data[k*DW +: DW] = rd_k;
  end

endmodule

// File: tb/tb_mem_mp.sv
// Self-checking bench for mem_mp: default 8/8/2 build plus a 16/4/4 build on a shared clock.
module tb_mem_mp;

`ifdef MEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_mp_if #(.DW(8),  .AW(8), .NRD(2)) b1 ();
  mem_mp_if #(.DW(16), .AW(4), .NRD(4)) b2 ();

  mem_mp #(.DW(8), .AW(8), .NRD(2)) u_dut1 (
    .clk (clk), .reset (reset), .bus (b1.slave)
  );

  mem_mp #(.DW(16), .AW(4), .NRD(4), .HALT_ADDR(4'hF)) u_dut2 (
    .clk (clk), .reset (reset), .bus (b2.slave)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        we;
    logic [7:0]  wa, wd, ra0, ra1, e0, e1;
    logic        h;
    logic [15:0] wc;
  } tvec_t;

  tvec_t tv[11];
  logic [15:0] q1[$];
  logic [63:0] q2[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step1(input tvec_t v);
    logic [15:0] e;
    b1.wr_en   = v.we;
    b1.wr_addr = v.wa;
    b1.wr_data = v.wd;
    b1.rd_addr = {v.ra1, v.ra0};
    q1.push_back({v.e1, v.e0});
    @(posedge clk); #1;
    e = q1.pop_front();
    chk("rd_data", 64'(b1.rd_data), 64'(e));
    b1.wr_en = 1'b0;
  endtask

  task automatic step2(input logic we, input logic [3:0] wa, input logic [15:0] wd,
                       input logic [15:0] ra, input logic [63:0] exp);
    logic [63:0] e;
    b2.wr_en   = we;
    b2.wr_addr = wa;
    b2.wr_data = wd;
    b2.rd_addr = ra;
    q2.push_back(exp);
    @(posedge clk); #1;
    e = q2.pop_front();
    chk("rd_data16", b2.rd_data, e);
    b2.wr_en = 1'b0;
  endtask

  task automatic count_clear(input bit pulse_wr);
    int n = 0;
    while (b1.busy && n < 300) begin
      b1.wr_en = pulse_wr;
      @(posedge clk); #1;
      n++;
    end
    b1.wr_en = 1'b0;
    chk("clear_cycles", 64'(n), 64'd256);
  endtask

  initial begin
    tvec_t v;
    b1.wr_en = 0; b1.wr_addr = 8'h10; b1.wr_data = 8'h55; b1.rd_addr = '0;
    b2.wr_en = 0; b2.wr_addr = '0;    b2.wr_data = '0;    b2.rd_addr = '0;

    tv[0]  = '{1'b1, 8'h10, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 16'd1};
    tv[1]  = '{1'b1, 8'h20, 8'h3C, 8'h10, 8'h30, 8'hA5, 8'h00, 1'b0, 16'd2};
    tv[2]  = '{1'b0, 8'h00, 8'h00, 8'h10, 8'h20, 8'hA5, 8'h3C, 1'b0, 16'd2};
    tv[3]  = '{1'b1, 8'h40, 8'h11, 8'h20, 8'h10, 8'h3C, 8'hA5, 1'b0, 16'd3};
    tv[4]  = '{1'b1, 8'h40, 8'h77, 8'h40, 8'hFF, (BYP ? 8'h77 : 8'h11), 8'h00, 1'b0, 16'd4};
    tv[5]  = '{1'b0, 8'h00, 8'h00, 8'h40, 8'h40, 8'h77, 8'h77, 1'b0, 16'd4};
    tv[6]  = '{1'b1, 8'hFF, 8'h02, 8'hFF, 8'h10, 8'h00, 8'hA5, 1'b0, 16'd5};
    tv[7]  = '{1'b1, 8'hFF, 8'h01, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 16'd6};
    tv[8]  = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h10, 8'h01, 8'hA5, 1'b1, 16'd6};
    tv[9]  = '{1'b1, 8'h10, 8'h99, 8'h10, 8'hFF, 8'hA5, 8'h01, 1'b1, 16'd6};
    tv[10] = '{1'b0, 8'h00, 8'h00, 8'h10, 8'h40, 8'hA5, 8'h77, 1'b1, 16'd6};

    // reset state
    #12;
    chk("rst_busy", 64'(b1.busy), 64'd1);
    chk("rst_halt", 64'(b1.halt), 64'd0);
    chk("rst_wcnt", 64'(b1.wr_count), 64'd0);
    chk("rst_rd",   64'(b1.rd_data), 64'd0);
    #18 reset = 1'b1;   // t=30

    // clear sequence with wr_en pulses that must be ignored
    count_clear(1'b1);
    chk("clear_wcnt", 64'(b1.wr_count), 64'd0);
    for (int a = 0; a < 128; a++) begin
      v = '{1'b0, 8'h00, 8'h00, 8'(a), 8'(a + 128), 8'h00, 8'h00, 1'b0, 16'd0};
      step1(v);
    end

    // table-driven write/read/collision/halt vectors
    for (int i = 0; i < 11; i++) begin
      step1(tv[i]);
      chk($sformatf("halt_%0d", i), 64'(b1.halt), 64'(tv[i].h));
      chk($sformatf("wcnt_%0d", i), 64'(b1.wr_count), 64'(tv[i].wc));
    end

    // async reset while halted
    #2 reset = 1'b0;
    #1;
    chk("rstH_halt", 64'(b1.halt), 64'd0);
    chk("rstH_busy", 64'(b1.busy), 64'd1);
    chk("rstH_rd",   64'(b1.rd_data), 64'd0);
    chk("rstH_wcnt", 64'(b1.wr_count), 64'd0);
    #1 reset = 1'b1;

    // async reset mid-clear, then a full clear must follow
    repeat (100) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("rstC_busy", 64'(b1.busy), 64'd1);
    chk("rstC_rd",   64'(b1.rd_data), 64'd0);
    #1 reset = 1'b1;
    count_clear(1'b0);
    v = '{1'b0, 8'h00, 8'h00, 8'h10, 8'h40, 8'h00, 8'h00, 1'b0, 16'd0};
    step1(v);
    v = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h20, 8'h00, 8'h00, 1'b0, 16'd0};
    step1(v);
    chk("post_halt", 64'(b1.halt), 64'd0);

    // 16-bit, 4-port build (already cleared by the shared reset)
    chk("b2_busy", 64'(b2.busy), 64'd0);
    step2(1'b1, 4'd1, 16'h1234, 16'h0000, 64'h0);
    step2(1'b1, 4'd2, 16'hBEEF, 16'h0000, 64'h0);
    step2(1'b1, 4'd5, 16'h0F0F, 16'h0000, 64'h0);
    step2(1'b1, 4'd9, 16'hC3A5, 16'h0000, 64'h0);
    step2(1'b0, 4'd0, 16'h0000, {4'd9, 4'd5, 4'd2, 4'd1}, 64'hC3A5_0F0F_BEEF_1234);
    step2(1'b0, 4'd0, 16'h0000, {4'd1, 4'd2, 4'd5, 4'd9}, 64'h1234_BEEF_0F0F_C3A5);
    step2(1'b0, 4'd0, 16'h0000, {4'd0, 4'd9, 4'd9, 4'd3}, 64'h0000_C3A5_C3A5_0000);
    chk("b2_wcnt", 64'(b2.wr_count), 64'd4);
    step2(1'b1, 4'hF, 16'h0001, {4'hF, 4'hF, 4'hF, 4'hF}, 64'h0);
    chk("b2_halt", 64'(b2.halt), 64'd1);
    step2(1'b1, 4'd1, 16'hFFFF, {4'd1, 4'hF, 4'd2, 4'hF}, 64'h1234_0001_BEEF_0001);
    step2(1'b0, 4'd0, 16'h0000, {4'd5, 4'd1, 4'd9, 4'd2}, 64'h0F0F_1234_C3A5_BEEF);
    chk("b2_wcnt_h", 64'(b2.wr_count), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
